load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
Memory-stage sequencer sitting directly upstream of the split data memory. Accepts one load/store request at a time from the execute stage over a valid/ready handshake and pre-checks alignment and mode. It drives the memory's enable/address/data/mode inputs for a fixed number of access cycles, then captures the load result and any fault flags into a registered response held for the writeback stage. Mode encodings are the shared LOAD_*/STORE_* defines from memory_defs.sv.

Parameters:
ACCESS_CYCLES, 1, cycles the memory port is held per access (>=1); future synchronous-read memory uses 2.

Ports:
i_Clock  input  1  clock, rising-edge.
i_Reset  input  1  asynchronous, active-high reset.
i_ReqValid  input  1  execute stage presents a request.
o_ReqReady  output  1  unit accepts a request this cycle.
i_ReqWrite  input  1  1 = store, 0 = load.
i_ReqAddress  input  32  byte address.
i_ReqData  input  32  store data, low-aligned.
i_ReqMode  input  3  LOAD_*/STORE_* mode code.
i_ReqRd  input  5  load destination register.
o_MemWriteEnable  output  1  to memory write enable.
o_MemReadEnable  output  1  to memory read enable.
o_MemAddress  output  32  to memory address.
o_MemDataOut  output  32  to memory data in.
o_MemMode  output  3  to memory mode.
i_MemDataIn  input  32  extended read data from memory.
i_MemMisaligned  input  1  memory misaligned flag.
i_MemBadInstruction  input  1  memory invalid-mode flag.
o_RespValid  output  1  response available.
i_RespReady  input  1  writeback consumes response.
o_RespData  output  32  load data (0 for stores/faults).
o_RespRd  output  5  destination register.
o_RespWriteReg  output  1  load, no fault, rd != 0.
o_RespCause  output  2  00 none, 01 misaligned, 10 bad mode.
o_RespBadAddress  output  32  faulting address, else 0.

Behaviour:
- Reset (async): state IDLE, access counter 0, every output 0 except o_ReqReady (comb, =1 in IDLE once reset deasserts). Reset mid-ACCESS abandons the access; memory enables drop immediately, no write commits after reset asserts, no response issued.
- States: IDLE, ACCESS, RESP.
- o_ReqReady = (IDLE) or (RESP and i_RespReady). Request accepted when i_ReqValid and o_ReqReady; all request fields latched.
- Pre-check on accept: misaligned if half modes with addr[0]=1 or word mode with addr[1:0]!=0 -> cause 01; mode not a load code when i_ReqWrite=0, or not a STORE_BYTE/HALF/WORD code when i_ReqWrite=1 -> cause 10 (bad mode wins over misaligned). Faulting request goes directly to RESP; memory enables never asserted.
- Clean request -> ACCESS for exactly ACCESS_CYCLES cycles (counter ACCESS_CYCLES-1 down to 0). o_MemAddress/DataOut/Mode driven from latched request throughout; o_MemReadEnable=1 all ACCESS cycles for loads; o_MemWriteEnable=1 only on final ACCESS cycle for stores (single write). Outside ACCESS both enables 0, address/data/mode hold last values.
- Final ACCESS cycle: sample i_MemDataIn (loads), i_MemMisaligned (-> cause 01), i_MemBadInstruction (-> cause 10, priority) into response registers; -> RESP.
- RESP: o_RespValid=1, all response fields stable until i_RespReady. On handshake: if new request accepted same cycle, go to ACCESS/RESP per its pre-check; else IDLE and o_RespValid=0 next cycle.
- Back-to-back throughput: one request per ACCESS_CYCLES+1 cycles with i_RespReady held high.
- Load-to-response latency: o_RespValid rises ACCESS_CYCLES+1 edges after acceptance; fault: 1 edge.
- o_RespData=0 and o_RespWriteReg=0 for stores and any fault; o_RespBadAddress=latched address only when cause!=00.

Test Plan:
- Reset then STORE_WORD 0xDEADBEEF @0x100, then LOAD_WORD @0x100, rd=5 -> one write pulse; response data 0xDEADBEEF, rd 5, WriteReg 1, cause 00, valid 2 edges after accept.
- LOAD_HALF @0x102 over word 0x8001_0000 -> data 0xFFFF8001; LOAD_HALF_UNSIGNED -> 0x00008001.
- LOAD_WORD @0x103 -> no memory enable ever asserted, response 1 edge later, cause 01, BadAddress 0x103, WriteReg 0.
- Store with a LOAD_BYTE mode code -> cause 10, no write; later load of that word returns prior contents.
- i_RespReady held 0 for 5 cycles -> o_RespValid and fields stable, o_ReqReady 0; release with new request pending -> accepted on same edge.
- Assert i_Reset during ACCESS of a STORE_WORD with ACCESS_CYCLES=2 -> enables 0 immediately, target word unchanged, o_RespValid 0.

Source files
------------

// File: rtl/load_store_unit.sv
`timescale 1ns/1ps
// load_store_unit: memory-stage sequencer between the execute stage and the
// split data memory. It takes one request at a time and pre-checks alignment
// and mode. It holds the memory port for ACCESS_CYCLES cycles, then keeps a
// registered response until the writeback stage takes it.
module load_store_unit #(
  parameter int ACCESS_CYCLES = 1
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic        i_ReqValid,
  output logic        o_ReqReady,
  input  logic        i_ReqWrite,
  input  logic [31:0] i_ReqAddress,
  input  logic [31:0] i_ReqData,
  input  logic [2:0]  i_ReqMode,
  input  logic [4:0]  i_ReqRd,
  output logic        o_MemWriteEnable,
  output logic        o_MemReadEnable,
  output logic [31:0] o_MemAddress,
  output logic [31:0] o_MemDataOut,
  output logic [2:0]  o_MemMode,
  input  logic [31:0] i_MemDataIn,
  input  logic        i_MemMisaligned,
  input  logic        i_MemBadInstruction,
  output logic        o_RespValid,
  input  logic        i_RespReady,
  output logic [31:0] o_RespData,
  output logic [4:0]  o_RespRd,
  output logic        o_RespWriteReg,
  output logic [1:0]  o_RespCause,
  output logic [31:0] o_RespBadAddress
);

  // Mode encodings shared with the data memory (memory_defs.sv).
  localparam logic [2:0] LOAD_BYTE          = 3'd0;
  localparam logic [2:0] LOAD_HALF          = 3'd1;
  localparam logic [2:0] LOAD_WORD          = 3'd2;
  localparam logic [2:0] LOAD_BYTE_UNSIGNED = 3'd3;
  localparam logic [2:0] LOAD_HALF_UNSIGNED = 3'd4;
  localparam logic [2:0] STORE_BYTE         = 3'd5;
  localparam logic [2:0] STORE_HALF         = 3'd6;
  localparam logic [2:0] STORE_WORD         = 3'd7;

  localparam int            CW             = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_COUNT     = CW'(ACCESS_CYCLES - 1);
  localparam logic          FIRST_IS_FINAL = (ACCESS_CYCLES == 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        r_state;
  logic [CW-1:0] r_count;
  logic          r_write;
  logic [31:0]   r_addr;
  logic [4:0]    r_rd;
  logic          r_mem_we;
  logic          r_mem_re;
  logic [31:0]   r_mem_addr;
  logic [31:0]   r_mem_data;
  logic [2:0]    r_mem_mode;
  logic          r_resp_valid;
  logic [31:0]   r_resp_data;
  logic [4:0]    r_resp_rd;
  logic          r_resp_write_reg;
  logic [1:0]    r_resp_cause;
  logic [31:0]   r_resp_bad_addr;

  logic       w_accept;
  logic       w_half;
  logic       w_word;
  logic       w_mode_ok;
  logic       w_misaligned;
  logic [1:0] w_req_cause;
  logic [1:0] w_mem_cause;
  logic       w_mem_ok;

  // Pre-check of the presented request; bad mode outranks misalignment.
  assign w_half       = i_ReqMode inside {LOAD_HALF, LOAD_HALF_UNSIGNED, STORE_HALF};
  assign w_word       = i_ReqMode inside {LOAD_WORD, STORE_WORD};
  assign w_mode_ok    = i_ReqWrite ? (i_ReqMode inside {STORE_BYTE, STORE_HALF, STORE_WORD})
                                   : (i_ReqMode inside {LOAD_BYTE, LOAD_HALF, LOAD_WORD,
                                                        LOAD_BYTE_UNSIGNED, LOAD_HALF_UNSIGNED});
  assign w_misaligned = (w_half && i_ReqAddress[0]) || (w_word && (i_ReqAddress[1:0] != 2'b00));
  assign w_req_cause  = !w_mode_ok ? 2'b10 : (w_misaligned ? 2'b01 : 2'b00);

  // Fault flags reported by the memory on the final access cycle.
  assign w_mem_cause  = i_MemBadInstruction ? 2'b10 : (i_MemMisaligned ? 2'b01 : 2'b00);
  assign w_mem_ok     = (w_mem_cause == 2'b00);

  // Combinational ready lets a response handshake and a new accept share one edge.
  assign o_ReqReady   = !i_Reset && ((r_state == IDLE) || ((r_state == RESP) && i_RespReady));
  assign w_accept     = i_ReqValid && o_ReqReady;

  // Request/access/response sequencing with all outputs registered.
  // NOTE: every register here uses <= so all reads in this block see the
  // pre-edge values, regardless of statement order.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_state          <= IDLE;
      r_count          <= '0;
      r_write          <= 1'b0;
      r_addr           <= '0;
      r_rd             <= '0;
      r_mem_we         <= 1'b0;
      r_mem_re         <= 1'b0;
      r_mem_addr       <= '0;
      r_mem_data       <= '0;
      r_mem_mode       <= '0;
      r_resp_valid     <= 1'b0;
      r_resp_data      <= '0;
      r_resp_rd        <= '0;
      r_resp_write_reg <= 1'b0;
      r_resp_cause     <= '0;
      r_resp_bad_addr  <= '0;
    end else if (w_accept) begin
      r_write <= i_ReqWrite;
      r_addr  <= i_ReqAddress;
      r_rd    <= i_ReqRd;
      if (w_req_cause != 2'b00) begin
        // Pre-check fault: answer at once, the memory port stays untouched.
        r_state          <= RESP;
        r_resp_valid     <= 1'b1;
        r_resp_data      <= '0;
        r_resp_rd        <= i_ReqRd;
        r_resp_write_reg <= 1'b0;
        r_resp_cause     <= w_req_cause;
        r_resp_bad_addr  <= i_ReqAddress;
      end else begin
        r_state      <= ACCESS;
        r_count      <= LAST_COUNT;
        r_resp_valid <= 1'b0;
        r_mem_addr   <= i_ReqAddress;
        r_mem_data   <= i_ReqData;
        r_mem_mode   <= i_ReqMode;
        r_mem_re     <= !i_ReqWrite;
        r_mem_we     <= i_ReqWrite && FIRST_IS_FINAL;
      end
    end else begin
      case (r_state)
        ACCESS: begin
          if (r_count == '0) begin
            r_state          <= RESP;
            r_mem_re         <= 1'b0;
            r_mem_we         <= 1'b0;
            r_resp_valid     <= 1'b1;
            r_resp_rd        <= r_rd;
            r_resp_cause     <= w_mem_cause;
            r_resp_data      <= (!r_write && w_mem_ok) ? i_MemDataIn : '0;
            r_resp_write_reg <= !r_write && w_mem_ok && (r_rd != 5'd0);
            r_resp_bad_addr  <= w_mem_ok ? '0 : r_addr;
          end else begin
            r_count  <= r_count - CW'(1);
            // The single write pulse lands on the last access cycle.
            r_mem_we <= r_write && (r_count == CW'(1));
          end
        end
        RESP: begin
          if (i_RespReady) begin
            r_state      <= IDLE;
            r_resp_valid <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_MemWriteEnable = r_mem_we;
  assign o_MemReadEnable  = r_mem_re;
  assign o_MemAddress     = r_mem_addr;
  assign o_MemDataOut     = r_mem_data;
  assign o_MemMode        = r_mem_mode;
  assign o_RespValid      = r_resp_valid;
  assign o_RespData       = r_resp_data;
  assign o_RespRd         = r_resp_rd;
  assign o_RespWriteReg   = r_resp_write_reg;
  assign o_RespCause      = r_resp_cause;
  assign o_RespBadAddress = r_resp_bad_addr;

endmodule

// File: tb/tb_load_store_unit.sv
`timescale 1ns/1ps
// tb_load_store_unit: drives two instances (one- and two-cycle access) with
// directed and random requests. A byte-level reference memory predicts each
// response; a word-level data memory model sits behind each instance.
module tb_load_store_unit;

  localparam logic [2:0] LB = 3'd0, LH = 3'd1, LW = 3'd2, LBU = 3'd3, LHU = 3'd4;
  localparam logic [2:0] SB = 3'd5, SH = 3'd6, SW = 3'd7;
  localparam int ACA = 1;
  localparam int ACB = 2;

  typedef struct {
    logic [1:0]  cause;
    logic [31:0] data;
    logic        wreg;
    logic [4:0]  rd;
    logic [31:0] bad;
    int          lat;
    int          writes;
    int          reads;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A (single access cycle)
  logic        a_rst, a_req_valid, a_req_ready, a_req_write, a_resp_ready;
  logic [31:0] a_req_addr, a_req_data;
  logic [2:0]  a_req_mode;
  logic [4:0]  a_req_rd;
  logic        a_mem_we, a_mem_re, a_mem_mis, a_mem_bad;
  logic [31:0] a_mem_addr, a_mem_dout, a_mem_din;
  logic [2:0]  a_mem_mode;
  logic        a_resp_valid, a_resp_wr;
  logic [31:0] a_resp_data, a_resp_bad;
  logic [4:0]  a_resp_rd;
  logic [1:0]  a_resp_cause;

  // Instance B (two access cycles)
  logic        b_rst, b_req_valid, b_req_ready, b_req_write, b_resp_ready;
  logic [31:0] b_req_addr, b_req_data;
  logic [2:0]  b_req_mode;
  logic [4:0]  b_req_rd;
  logic        b_mem_we, b_mem_re, b_mem_mis, b_mem_bad;
  logic [31:0] b_mem_addr, b_mem_dout, b_mem_din;
  logic [2:0]  b_mem_mode;
  logic        b_resp_valid, b_resp_wr;
  logic [31:0] b_resp_data, b_resp_bad;
  logic [4:0]  b_resp_rd;
  logic [1:0]  b_resp_cause;

  logic inj_mis = 1'b0;
  logic inj_bad = 1'b0;

  load_store_unit #(.ACCESS_CYCLES(ACA)) dut_a (
    .i_Clock(clk), .i_Reset(a_rst),
    .i_ReqValid(a_req_valid), .o_ReqReady(a_req_ready), .i_ReqWrite(a_req_write),
    .i_ReqAddress(a_req_addr), .i_ReqData(a_req_data), .i_ReqMode(a_req_mode), .i_ReqRd(a_req_rd),
    .o_MemWriteEnable(a_mem_we), .o_MemReadEnable(a_mem_re), .o_MemAddress(a_mem_addr),
    .o_MemDataOut(a_mem_dout), .o_MemMode(a_mem_mode), .i_MemDataIn(a_mem_din),
    .i_MemMisaligned(a_mem_mis), .i_MemBadInstruction(a_mem_bad),
    .o_RespValid(a_resp_valid), .i_RespReady(a_resp_ready), .o_RespData(a_resp_data),
    .o_RespRd(a_resp_rd), .o_RespWriteReg(a_resp_wr), .o_RespCause(a_resp_cause),
    .o_RespBadAddress(a_resp_bad)
  );

  load_store_unit #(.ACCESS_CYCLES(ACB)) dut_b (
    .i_Clock(clk), .i_Reset(b_rst),
    .i_ReqValid(b_req_valid), .o_ReqReady(b_req_ready), .i_ReqWrite(b_req_write),
    .i_ReqAddress(b_req_addr), .i_ReqData(b_req_data), .i_ReqMode(b_req_mode), .i_ReqRd(b_req_rd),
    .o_MemWriteEnable(b_mem_we), .o_MemReadEnable(b_mem_re), .o_MemAddress(b_mem_addr),
    .o_MemDataOut(b_mem_dout), .o_MemMode(b_mem_mode), .i_MemDataIn(b_mem_din),
    .i_MemMisaligned(b_mem_mis), .i_MemBadInstruction(b_mem_bad),
    .o_RespValid(b_resp_valid), .i_RespReady(b_resp_ready), .o_RespData(b_resp_data),
    .o_RespRd(b_resp_rd), .o_RespWriteReg(b_resp_wr), .o_RespCause(b_resp_cause),
    .o_RespBadAddress(b_resp_bad)
  );

  // Data memory models: word arrays, extended reads, writes on the enable.
  function automatic logic [31:0] mem_extend(input logic [31:0] word, input logic [1:0] off,
                                             input logic [2:0] mode);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[8*int'(off) +: 8];
    h = word[16*int'(off[1]) +: 16];
    case (mode)
      LB:      return {{24{b[7]}}, b};
      LBU:     return {24'd0, b};
      LH:      return {{16{h[15]}}, h};
      LHU:     return {16'd0, h};
      LW:      return word;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] mem_merge(input logic [31:0] word, input logic [1:0] off,
                                            input logic [2:0] mode, input logic [31:0] data);
    logic [31:0] w;
    w = word;
    case (mode)
      SB:      w[8*int'(off) +: 8] = data[7:0];
      SH:      w[16*int'(off[1]) +: 16] = data[15:0];
      SW:      w = data;
      default: w = word;
    endcase
    return w;
  endfunction

  logic [31:0] phys_a [256] = '{default: '0};
  logic [31:0] phys_b [256] = '{default: '0};
  logic [7:0]  ref_mem [1024] = '{default: '0};

  assign a_mem_din = mem_extend(phys_a[a_mem_addr[9:2]], a_mem_addr[1:0], a_mem_mode);
  assign b_mem_din = mem_extend(phys_b[b_mem_addr[9:2]], b_mem_addr[1:0], b_mem_mode);
  assign a_mem_mis = inj_mis;
  assign a_mem_bad = inj_bad;
  assign b_mem_mis = 1'b0;
  assign b_mem_bad = 1'b0;

  int a_we_cnt = 0, a_re_cnt = 0, a_acc_cnt = 0, b_we_cnt = 0, b_re_cnt = 0;
  int a_we0 = 0, a_re0 = 0;

  always @(posedge clk) begin
    if (a_mem_we && !a_mem_mis && !a_mem_bad)
      phys_a[a_mem_addr[9:2]] <= mem_merge(phys_a[a_mem_addr[9:2]], a_mem_addr[1:0], a_mem_mode, a_mem_dout);
    if (b_mem_we)
      phys_b[b_mem_addr[9:2]] <= mem_merge(phys_b[b_mem_addr[9:2]], b_mem_addr[1:0], b_mem_mode, b_mem_dout);
    if (a_mem_we) a_we_cnt <= a_we_cnt + 1;
    if (a_mem_re) a_re_cnt <= a_re_cnt + 1;
    if (a_req_valid && a_req_ready) a_acc_cnt <= a_acc_cnt + 1;
    if (b_mem_we) b_we_cnt <= b_we_cnt + 1;
    if (b_mem_re) b_re_cnt <= b_re_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: byte-addressed memory, sizes and sign rules in plain arithmetic.
  task automatic predict(input logic w, input logic [31:0] addr, input logic [31:0] data,
                         input logic [2:0] mode, input logic [4:0] rd, input logic im,
                         input logic ib, output exp_t e);
    int     size, a;
    logic   pre_bad, pre_mis;
    longint val;
    size    = (mode == LB || mode == LBU || mode == SB) ? 1 : ((mode == LW || mode == SW) ? 4 : 2);
    pre_bad = w ? (mode < SB) : (mode > LHU);
    pre_mis = (int'(addr[9:0]) % size) != 0;
    e.cause = pre_bad ? 2'd2 : (pre_mis ? 2'd1 : (ib ? 2'd2 : (im ? 2'd1 : 2'd0)));
    e.lat    = (pre_bad || pre_mis) ? 1 : ACA + 1;
    e.writes = (!(pre_bad || pre_mis) && w) ? 1 : 0;
    e.reads  = (!(pre_bad || pre_mis) && !w) ? ACA : 0;
    e.data   = 32'd0;
    a = int'(addr[9:0]);
    if (e.cause == 2'd0) begin
      if (w) begin
        for (int i = 0; i < size; i++) ref_mem[a + i] = data[8*i +: 8];
      end else begin
        val = 0;
        for (int i = 0; i < size; i++) val += longint'(ref_mem[a + i]) << (8 * i);
        if ((mode == LB || mode == LH) && val >= (64'sd1 <<< (8 * size - 1)))
          val -= (64'sd1 <<< (8 * size));
        e.data = val[31:0];
      end
    end
    e.wreg = !w && (e.cause == 2'd0) && (rd != 5'd0);
    e.rd   = rd;
    e.bad  = (e.cause != 2'd0) ? addr : 32'd0;
  endtask

  task automatic a_issue(input logic w, input logic [31:0] addr, input logic [31:0] data,
                         input logic [2:0] mode, input logic [4:0] rd);
    int guard;
    @(negedge clk);
    a_req_valid = 1'b1; a_req_write = w; a_req_addr = addr;
    a_req_data = data; a_req_mode = mode; a_req_rd = rd; a_resp_ready = 1'b0;
    guard = 0;
    while (!a_req_ready && guard < 20) begin @(negedge clk); guard++; end
    check("a_req_ready", 32'(a_req_ready), 32'd1);
    a_we0 = a_we_cnt; a_re0 = a_re_cnt;
    @(posedge clk);
    @(negedge clk);
    a_req_valid = 1'b0;
  endtask

  task automatic a_wait_check(input exp_t e, input string tag);
    int lat;
    lat = 1;
    while (!a_resp_valid && lat < 20) begin @(posedge clk); lat++; @(negedge clk); end
    check({tag, "_latency"}, 32'(lat), 32'(e.lat));
    check({tag, "_cause"}, 32'(a_resp_cause), 32'(e.cause));
    check({tag, "_data"}, a_resp_data, e.data);
    check({tag, "_wreg"}, 32'(a_resp_wr), 32'(e.wreg));
    check({tag, "_rd"}, 32'(a_resp_rd), 32'(e.rd));
    check({tag, "_badaddr"}, a_resp_bad, e.bad);
    check({tag, "_writes"}, 32'(a_we_cnt - a_we0), 32'(e.writes));
    check({tag, "_reads"}, 32'(a_re_cnt - a_re0), 32'(e.reads));
  endtask

  task automatic a_handshake(input string tag);
    a_resp_ready = 1'b1;
    @(negedge clk);
    a_resp_ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(a_resp_valid), 32'd0);
  endtask

  task automatic a_run(input logic w, input logic [31:0] addr, input logic [31:0] data,
                       input logic [2:0] mode, input logic [4:0] rd, input string tag);
    exp_t e;
    predict(w, addr, data, mode, rd, inj_mis, inj_bad, e);
    a_issue(w, addr, data, mode, rd);
    a_wait_check(e, tag);
    a_handshake(tag);
  endtask

  task automatic b_issue(input logic w, input logic [31:0] addr, input logic [31:0] data,
                         input logic [2:0] mode, input logic [4:0] rd);
    int guard;
    @(negedge clk);
    b_req_valid = 1'b1; b_req_write = w; b_req_addr = addr;
    b_req_data = data; b_req_mode = mode; b_req_rd = rd; b_resp_ready = 1'b0;
    guard = 0;
    while (!b_req_ready && guard < 20) begin @(negedge clk); guard++; end
    check("b_req_ready", 32'(b_req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    b_req_valid = 1'b0;
  endtask

  task automatic b_wait(output int lat);
    lat = 1;
    while (!b_resp_valid && lat < 20) begin @(posedge clk); lat++; @(negedge clk); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    exp_t        e1, e2;
    int          acc0, lat, re0, we0;
    logic        w;
    logic [2:0]  mode;
    logic [31:0] addr, data;
    logic [4:0]  rd;

    a_req_valid = 0; a_req_write = 0; a_req_addr = 0; a_req_data = 0; a_req_mode = 0; a_req_rd = 0;
    a_resp_ready = 0;
    b_req_valid = 0; b_req_write = 0; b_req_addr = 0; b_req_data = 0; b_req_mode = 0; b_req_rd = 0;
    b_resp_ready = 0;
    a_rst = 1'b0; b_rst = 1'b0;
    #1;
    a_rst = 1'b1; b_rst = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_req_ready", 32'(a_req_ready), 32'd0);
    check("rst_mem_we", 32'(a_mem_we), 32'd0);
    check("rst_mem_re", 32'(a_mem_re), 32'd0);
    check("rst_mem_addr", a_mem_addr, 32'd0);
    check("rst_mem_dout", a_mem_dout, 32'd0);
    check("rst_mem_mode", 32'(a_mem_mode), 32'd0);
    check("rst_resp_valid", 32'(a_resp_valid), 32'd0);
    check("rst_resp_data", a_resp_data, 32'd0);
    check("rst_resp_rd", 32'(a_resp_rd), 32'd0);
    check("rst_resp_wreg", 32'(a_resp_wr), 32'd0);
    check("rst_resp_cause", 32'(a_resp_cause), 32'd0);
    check("rst_resp_bad", a_resp_bad, 32'd0);
    a_rst = 1'b0; b_rst = 1'b0;
    #1;
    check("rst_release_ready", 32'(a_req_ready), 32'd1);

    // Store word then load it back
    a_run(1'b1, 32'h100, 32'hDEADBEEF, SW, 5'd0, "sw_100");
    a_run(1'b0, 32'h100, 32'd0, LW, 5'd5, "lw_100");

    // Signed and unsigned half loads from the upper half
    a_run(1'b1, 32'h100, 32'h80010000, SW, 5'd0, "sw_8001");
    a_run(1'b0, 32'h102, 32'd0, LH, 5'd7, "lh_102");
    a_run(1'b0, 32'h102, 32'd0, LHU, 5'd8, "lhu_102");

    // Misaligned word load faults without touching memory
    a_run(1'b0, 32'h103, 32'd0, LW, 5'd9, "lw_103");

    // Store carrying a load mode code is rejected; memory keeps old contents
    a_run(1'b1, 32'h100, 32'h12345678, LB, 5'd0, "st_badmode");
    a_run(1'b0, 32'h100, 32'd0, LW, 5'd1, "lw_after_bad");

    // Response held under backpressure, then handshake and accept on one edge
    predict(1'b0, 32'h100, 32'd0, LW, 5'd10, 1'b0, 1'b0, e1);
    a_issue(1'b0, 32'h100, 32'd0, LW, 5'd10);
    a_wait_check(e1, "hold_first");
    predict(1'b0, 32'h102, 32'd0, LHU, 5'd11, 1'b0, 1'b0, e2);
    a_req_valid = 1'b1; a_req_write = 1'b0; a_req_addr = 32'h102; a_req_mode = LHU; a_req_rd = 5'd11;
    repeat (5) begin
      @(negedge clk);
      check("hold_valid", 32'(a_resp_valid), 32'd1);
      check("hold_data", a_resp_data, e1.data);
      check("hold_rd", 32'(a_resp_rd), 32'd10);
      check("hold_req_ready", 32'(a_req_ready), 32'd0);
    end
    a_resp_ready = 1'b1;
    a_we0 = a_we_cnt; a_re0 = a_re_cnt; acc0 = a_acc_cnt;
    @(posedge clk);
    @(negedge clk);
    a_req_valid = 1'b0; a_resp_ready = 1'b0;
    check("hold_accept_same_edge", 32'(a_acc_cnt - acc0), 32'd1);
    a_wait_check(e2, "hold_second");
    a_handshake("hold_second");

    // Faults reported by the memory itself on the last access cycle
    inj_mis = 1'b1; inj_bad = 1'b1;
    a_run(1'b0, 32'h100, 32'd0, LW, 5'd4, "inj_load");
    inj_bad = 1'b0;
    a_run(1'b1, 32'h104, 32'h55AA55AA, SW, 5'd0, "inj_store");
    inj_mis = 1'b0;
    a_run(1'b0, 32'h104, 32'd0, LW, 5'd6, "inj_check");

    // Back-to-back throughput with both handshakes held high
    acc0 = a_acc_cnt;
    @(negedge clk);
    a_req_valid = 1'b1; a_req_write = 1'b0; a_req_addr = 32'h100; a_req_mode = LW; a_req_rd = 5'd1;
    a_resp_ready = 1'b1;
    repeat (12) @(posedge clk);
    @(negedge clk);
    a_req_valid = 1'b0;
    check("tput_accepts", 32'(a_acc_cnt - acc0), 32'(12 / (ACA + 1)));
    @(negedge clk);
    a_resp_ready = 1'b0;
    @(negedge clk);
    check("tput_idle", 32'(a_resp_valid), 32'd0);

    // Random traffic against the reference model
    for (int n = 0; n < 40; n++) begin
      w    = 1'($urandom_range(0, 1));
      mode = 3'($urandom_range(0, 7));
      addr = 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
      data = $urandom;
      rd   = 5'($urandom_range(0, 31));
      a_run(w, addr, data, mode, rd, "rand");
    end

    // Two-cycle access instance: latency, data, and reset during a store
    b_issue(1'b1, 32'h40, 32'h11223344, SW, 5'd0);
    b_wait(lat);
    check("b_store_latency", 32'(lat), 32'(ACB + 1));
    check("b_store_cause", 32'(b_resp_cause), 32'd0);
    check("b_store_mem", phys_b[16], 32'h11223344);
    b_resp_ready = 1'b1;
    @(negedge clk);
    b_resp_ready = 1'b0;
    re0 = b_re_cnt;
    b_issue(1'b0, 32'h40, 32'd0, LW, 5'd3);
    b_wait(lat);
    check("b_load_latency", 32'(lat), 32'(ACB + 1));
    check("b_load_data", b_resp_data, 32'h11223344);
    check("b_load_wreg", 32'(b_resp_wr), 32'd1);
    check("b_load_reads", 32'(b_re_cnt - re0), 32'(ACB));
    b_resp_ready = 1'b1;
    @(negedge clk);
    b_resp_ready = 1'b0;
    we0 = b_we_cnt;
    b_issue(1'b1, 32'h40, 32'hCAFEF00D, SW, 5'd0);
    check("b_we_first_cycle", 32'(b_mem_we), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("b_we_final_cycle", 32'(b_mem_we), 32'd1);
    #1;
    b_rst = 1'b1;
    #1;
    check("b_rst_we", 32'(b_mem_we), 32'd0);
    check("b_rst_re", 32'(b_mem_re), 32'd0);
    check("b_rst_valid", 32'(b_resp_valid), 32'd0);
    check("b_rst_ready", 32'(b_req_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("b_rst_mem_unchanged", phys_b[16], 32'h11223344);
    b_rst = 1'b0;
    #1;
    check("b_release_ready", 32'(b_req_ready), 32'd1);
    repeat (3) @(negedge clk);
    check("b_no_response", 32'(b_resp_valid), 32'd0);
    check("b_no_write", 32'(b_we_cnt - we0), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
